// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx: line, frame format, consumer handshake and
// received word with status. The master is the surrounding system (line,
// baud tick, format, consumer); the slave is the receiver.
interface uart_rx_if;
  logic       tick;
  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       rts_n;

  modport master (
    output tick, rx, data_bit_num, stop_bit_num, parity_en, parity_type, rx_ack,
    input  rx_data, rx_done, parity_err, frame_err, overrun_err, rts_n
  );

  modport slave (
    input  tick, rx, data_bit_num, stop_bit_num, parity_en, parity_type, rx_ack,
    output rx_data, rx_done, parity_err, frame_err, overrun_err, rts_n
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, LSB-first deserialisation of
// 5..8 data bits with optional parity and 1 or 2 stop bits, status flags and
// rts_n flow control for back-to-back use with uart_tx.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input logic     clk,
  input logic     rst_n,
  uart_rx_if.slave bus
);
  localparam int            CW      = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    fmt_bits_q, fmt_bits_d;
  logic          fmt_stop2_q, fmt_stop2_d;
  logic          fmt_par_en_q, fmt_par_en_d;
  logic          fmt_par_odd_q, fmt_par_odd_d;
  logic          par_bit_q, par_bit_d;
  logic          stop_err_q, stop_err_d;
  logic          armed_q, armed_d;
  logic          frame_end;

  logic [7:0]    rx_data_q, rx_data_d;
  logic          done_q, done_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          rts_q, rts_d;
  logic [7:0]    data_aligned;

  // Two-flop synchroniser for the asynchronous serial line.
  // NOTE: both flops reset to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rx_meta_q <= bus.rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // FSM state and frame datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      fmt_bits_q    <= '0;
      fmt_stop2_q   <= 1'b0;
      fmt_par_en_q  <= 1'b0;
      fmt_par_odd_q <= 1'b0;
      par_bit_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      fmt_bits_q    <= fmt_bits_d;
      fmt_stop2_q   <= fmt_stop2_d;
      fmt_par_en_q  <= fmt_par_en_d;
      fmt_par_odd_q <= fmt_par_odd_d;
      par_bit_q     <= par_bit_d;
      stop_err_q    <= stop_err_d;
      armed_q       <= armed_d;
    end
  end

  // Next-state logic: everything here advances only on oversample ticks.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    fmt_bits_d    = fmt_bits_q;
    fmt_stop2_d   = fmt_stop2_q;
    fmt_par_en_d  = fmt_par_en_q;
    fmt_par_odd_d = fmt_par_odd_q;
    par_bit_d     = par_bit_q;
    stop_err_d    = stop_err_q;
    armed_d       = armed_q;
    frame_end     = 1'b0;
    if (bus.tick) begin
      unique case (state_q)
        IDLE: begin
          if (rxs_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // Falling edge after a seen high level: freeze the frame format.
            state_d       = START;
            tick_cnt_d    = '0;
            bit_cnt_d     = '0;
            stop_err_d    = 1'b0;
            fmt_bits_d    = bus.data_bit_num;
            fmt_stop2_d   = bus.stop_bit_num;
            fmt_par_en_d  = bus.parity_en;
            fmt_par_odd_d = bus.parity_type;
          end
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            state_d    = rxs_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rxs_q, shift_q[7:1]};
            if (bit_cnt_q == {1'b0, fmt_bits_q} + 3'd4) begin
              bit_cnt_d = '0;
              state_d   = fmt_par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            par_bit_d  = rxs_q;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            if (!rxs_q) stop_err_d = 1'b1;
            if (bit_cnt_q[0] == fmt_stop2_q) begin
              // Leave mid-stop-bit; a low last stop (break) disarms start detection.
              state_d   = IDLE;
              bit_cnt_d = '0;
              armed_d   = rxs_q;
              frame_end = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status next-state: frame results on completion, rts/overrun handshake.
  always_comb begin
    data_aligned = shift_q >> (2'd3 - fmt_bits_q);
    rx_data_d    = rx_data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    rts_d        = rts_q;
    done_d       = frame_end;
    if (frame_end) begin
      rx_data_d    = data_aligned;
      parity_err_d = fmt_par_en_q && ((^data_aligned ^ par_bit_q) != fmt_par_odd_q);
      frame_err_d  = stop_err_d;
    end
    if (done_q) begin
      // A new frame always wins over a simultaneous acknowledge.
      overrun_d = rts_q & ~bus.rx_ack;
      rts_d     = 1'b1;
    end else if (bus.rx_ack && rts_q) begin
      rts_d = 1'b0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rts_q        <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rts_q        <= rts_d;
    end
  end

  // Outputs: during the rx_done cycle rts_n is already high and overrun
  // reflects whether the consumer acknowledges in that same cycle.
  always_comb begin
    bus.rx_data     = rx_data_q;
    bus.rx_done     = done_q;
    bus.parity_err  = parity_err_q;
    bus.frame_err   = frame_err_q;
    bus.overrun_err = done_q ? (rts_q & ~bus.rx_ack) : overrun_q;
    bus.rts_n       = rts_q | done_q;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the receive-side counterpart of the existing uart_tx.
- Oversamples the serial line using the shared baud_generator tick (16 ticks per bit) and deserialises LSB-first frames with a configurable format.
- Reports the received byte with parity, framing and overrun status.
- Drives rts_n for hardware flow control, so it can be wired back-to-back with uart_tx through cts_n.

Parameters:
OVERSAMPLE, 16, ticks per bit period; must be even and at least 8.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick  input  1  one-clk-wide oversample strobe from baud_generator
rx  input  1  serial line, idle high, asynchronous to clk
data_bit_num  input  2  data bits: 00=5, 01=6, 10=7, 11=8
stop_bit_num  input  1  0=1 stop bit, 1=2 stop bits
parity_en  input  1  1=parity bit present after data
parity_type  input  1  0=even, 1=odd
rx_ack  input  1  one-clk pulse: consumer has read rx_data
rx_data  output  8  received word, right-justified, unused MSBs zero
rx_done  output  1  one-clk pulse: new frame complete
parity_err  output  1  parity mismatch on last frame
frame_err  output  1  a stop bit sampled low on last frame
overrun_err  output  1  last frame completed while previous one unread
rts_n  output  1  0=ready to receive, 1=holding unread data

Behaviour:
- Reset is asynchronous and active-low.
  - rx_data=0; rx_done, parity_err, frame_err and overrun_err all 0; rts_n=0.
  - FSM goes to IDLE; tick counter and bit counter go to 0.
  - Both rx synchroniser flops reset to 1.
- rx passes through a 2-flop synchroniser; the FSM sees only the synchronised value rxs.
- Only clocks with tick=1 advance the tick counter. All other state changes happen on tick cycles, except rx_done, rx_ack handling and reset.
- Frame format is latched on leaving IDLE: data_bit_num, stop_bit_num, parity_en, parity_type. Changes mid-frame have no effect.
- FSM states:
  - IDLE: on a tick with rxs=0, clear the tick counter and go to START.
  - START: count ticks. On the (OVERSAMPLE/2)th tick, sample rxs.
    - rxs=0: clear counter, go to DATA.
    - rxs=1: false start, return to IDLE with no outputs.
  - DATA: on every OVERSAMPLE-th tick, shift rxs into the MSB of the shift register (LSB first on the line).
    - After N bits (N=5..8), go to PARITY if parity_en=1, else STOP.
  - PARITY: on the OVERSAMPLE-th tick, capture rxs.
    - Error if the XOR of the N data bits and the parity bit is not equal to parity_type.
  - STOP: on each OVERSAMPLE-th tick, sample one stop bit (1 or 2 samples).
    - Any low sample sets the frame error.
    - After the last stop sample, go to IDLE and complete the frame. Return happens mid-stop-bit, so a start edge that follows immediately is caught.
- Frame completion, on the clock after the last stop sample:
  - rx_done=1 for exactly one clk.
  - rx_data = shift register right-aligned to N bits, upper 8-N bits zero.
  - parity_err and frame_err are updated; they and rx_data hold until the next rx_done.
  - overrun_err = (rts_n==1 at completion and no rx_ack in the same cycle). The new data overwrites the old.
  - rts_n goes to 1 in the same cycle as rx_done.
- rx_ack:
  - rx_ack while rts_n=1 and no rx_done: rts_n goes to 0 next cycle.
  - rx_ack while rts_n=0: ignored.
  - rx_ack and rx_done in the same cycle: new frame wins, rts_n stays 1, overrun_err=0.
- rts_n does not gate reception. A frame already in progress always completes.
- Latency: rx_done occurs 2 clk (synchroniser) + 1 clk after the tick at the middle of the final stop bit.
- Reset asserted mid-frame: immediate return to the reset state. The partial frame is discarded and no rx_done is produced.
- A break condition (line held low) causes frame_err=1, rx_data=0, then IDLE. A new frame is accepted only after rxs returns high and falls again: IDLE requires rxs=1 to have been seen since the previous frame.

Test Plan:
- Tick every 4 clk, 8N1, no parity, send 0xA5 -> one rx_done pulse; rx_data=0xA5; all three error flags 0; rts_n=1 until rx_ack, then 0 the following clk.
- 7E2 (data_bit_num=10, parity_en=1, parity_type=0, stop_bit_num=1), send 0x35 with correct parity 0 -> rx_data=0x35, parity_err=0. Repeat with parity bit forced to 1 -> parity_err=1, rx_data=0x35.
- 5-bit format, send 0x1F with the stop bit driven low -> rx_data=0x1F, frame_err=1, upper 3 bits of rx_data zero.
- rx low glitch of 5 ticks from idle (shorter than OVERSAMPLE/2) -> no rx_done, FSM back in IDLE; a following valid 0x3C frame is received correctly.
- Two back-to-back 8N1 frames 0x11, 0x22 with no rx_ack -> second rx_done has rx_data=0x22 and overrun_err=1. Repeat with rx_ack pulsed in the exact cycle of the second rx_done -> overrun_err=0, rts_n stays 1.
- Assert rst_n low during bit 4 of a frame, release, then send 0x81 -> all outputs at reset values during reset, no spurious rx_done, 0x81 received cleanly.
